// File: rtl/dmem_pkg.sv
// Shared constants for the data-cache backing memory: FSM state encoding,
// default geometry/latency and the fixed latency-counter width.
package dmem_pkg;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_BUSY = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam int DMEM_LATENCY = 4;
   localparam int DMEM_DEPTH   = 1024;

   // Wide enough for the largest legal latency (255).
   localparam int CNT_W = 8;

endpackage

// File: rtl/dmem_array.sv
// Single-port synchronous word RAM with a registered read port.
// No reset on the storage or read register so it maps onto block RAM.
module dmem_array #(
   parameter int DEPTH = 1024,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we_i,
   input  logic          re_i,
   input  logic [AW-1:0] addr_i,
   input  logic [31:0]   wdata_i,
   output logic [31:0]   rdata_o
);

   logic [31:0] mem_q [DEPTH];
   logic [31:0] rdata_q;

   always_ff @(posedge clk) begin
      if (we_i) mem_q[addr_i] <= wdata_i;
      if (re_i) rdata_q <= mem_q[addr_i];
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/data_memory_ctrl.sv
// Multi-cycle backing memory for the data cache: latches one request, waits
// LATENCY cycles, performs the access and returns a one-cycle ready pulse.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | waiting for mem_read_en/mem_write_en; request latched on accept
// BUSY   | counting down the access latency; access happens when cnt == 0
// DONE   | mem_ready (and mem_error if illegal) high for this one cycle
module data_memory_ctrl
   import dmem_pkg::*;
#(
   parameter int DEPTH_WORDS = DMEM_DEPTH,
   parameter int LATENCY     = DMEM_LATENCY
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        mem_read_en,
   input  logic        mem_write_en,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_wdata,
   output logic [31:0] mem_rdata,
   output logic        mem_ready,
   output logic        mem_busy,
   output logic        mem_error
);

   localparam int IDX_W = $clog2(DEPTH_WORDS);
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             wr_q, wr_d;
   logic             err_q, err_d;
   logic             oor_q, oor_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [31:0]      wdata_q, wdata_d;
   logic             ready_q, ready_d;
   logic             error_q, error_d;
   logic             busy_q, busy_d;
   logic             rd_ok_q, rd_ok_d;

   logic        req;
   logic        addr_oor;
   logic        access;
   logic        arr_we, arr_re;
   logic [31:0] arr_rdata;
   logic        unused_addr_lsb;

   assign req             = mem_read_en | mem_write_en;
   assign addr_oor        = {2'b00, mem_addr[31:2]} >= 32'(DEPTH_WORDS);
   assign access          = (state_q == S_BUSY) && (cnt_q == '0);
   assign unused_addr_lsb = ^mem_addr[1:0];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         wr_q    <= 1'b0;
         err_q   <= 1'b0;
         oor_q   <= 1'b0;
         idx_q   <= '0;
         wdata_q <= '0;
         ready_q <= 1'b0;
         error_q <= 1'b0;
         busy_q  <= 1'b0;
         rd_ok_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         wr_q    <= wr_d;
         err_q   <= err_d;
         oor_q   <= oor_d;
         idx_q   <= idx_d;
         wdata_q <= wdata_d;
         ready_q <= ready_d;
         error_q <= error_d;
         busy_q  <= busy_d;
         rd_ok_q <= rd_ok_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (req) state_d = S_BUSY;
         S_BUSY:  if (cnt_q == '0) state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Request latch and latency counter; a simultaneous read+write is a write.
   always_comb begin
      cnt_d   = cnt_q;
      wr_d    = wr_q;
      err_d   = err_q;
      oor_d   = oor_q;
      idx_d   = idx_q;
      wdata_d = wdata_q;
      if (state_q == S_IDLE && req) begin
         cnt_d   = CNT_INIT;
         wr_d    = mem_write_en;
         oor_d   = addr_oor;
         err_d   = addr_oor | (mem_read_en & mem_write_en);
         idx_d   = mem_addr[IDX_W+1:2];
         wdata_d = mem_wdata;
      end else if (state_q == S_BUSY && cnt_q != '0) begin
         cnt_d = cnt_q - 8'd1;
      end
   end

   always_comb begin
      ready_d = access;
      error_d = access & err_q;
      busy_d  = (state_d != S_IDLE);
      rd_ok_d = rd_ok_q;
      if (access && !wr_q) rd_ok_d = ~oor_q;
   end

   assign arr_we = access & wr_q & ~oor_q;
   assign arr_re = access & ~wr_q & ~oor_q;

   dmem_array #(
      .DEPTH (DEPTH_WORDS),
      .AW    (IDX_W)
   ) u_array (
      .clk     (clk),
      .we_i    (arr_we),
      .re_i    (arr_re),
      .addr_i  (idx_q),
      .wdata_i (wdata_q),
      .rdata_o (arr_rdata)
   );

   // An out-of-range read (or no read since reset) presents zero.
   assign mem_rdata = rd_ok_q ? arr_rdata : 32'h0;
   assign mem_ready = ready_q;
   assign mem_busy  = busy_q;
   assign mem_error = error_q;

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Scoreboard bench: two controllers (LATENCY 4 and 1) driven by a cache-like
// requester; expectations come from a word-array model of the memory.
module tb_data_memory_ctrl;

   localparam int DEPTH = 1024;

   typedef struct {
      int          cyc;
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        rd_en [2];
   logic        wr_en [2];
   logic [31:0] addr  [2];
   logic [31:0] wd    [2];
   logic [31:0] rdata [2];
   logic        ready [2];
   logic        busy  [2];
   logic        err   [2];

   logic [31:0] mdl   [2][DEPTH];
   logic [31:0] last  [2];
   logic [31:0] shown [2];
   int          bfrom [2];
   int          bto   [2];
   exp_t        q0[$];
   exp_t        q1[$];
   int          cyc = 0;
   int          n_chk = 0;
   int          n_pass = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   data_memory_ctrl #(.DEPTH_WORDS(DEPTH), .LATENCY(4)) dut0 (
      .clk(clk), .reset(rst_n), .mem_read_en(rd_en[0]), .mem_write_en(wr_en[0]),
      .mem_addr(addr[0]), .mem_wdata(wd[0]), .mem_rdata(rdata[0]),
      .mem_ready(ready[0]), .mem_busy(busy[0]), .mem_error(err[0]));

   data_memory_ctrl #(.DEPTH_WORDS(DEPTH), .LATENCY(1)) dut1 (
      .clk(clk), .reset(rst_n), .mem_read_en(rd_en[1]), .mem_write_en(wr_en[1]),
      .mem_addr(addr[1]), .mem_wdata(wd[1]), .mem_rdata(rdata[1]),
      .mem_ready(ready[1]), .mem_busy(busy[1]), .mem_error(err[1]));

   function automatic int lat(input int u);
      return (u == 0) ? 4 : 1;
   endfunction

   function automatic int qsize(input int u);
      return (u == 0) ? q0.size() : q1.size();
   endfunction

   task automatic chk(input string nm, input int u, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s unit%0d cycle %0d: got %h expected %h", nm, u, cyc, act, exp);
   endtask

   task automatic push_exp(input int u, input exp_t e);
      if (u == 0) q0.push_back(e);
      else q1.push_back(e);
   endtask

   task automatic pop_exp(input int u, output exp_t e);
      if (u == 0) e = q0.pop_front();
      else e = q1.pop_front();
   endtask

   // Monitor: every cycle, compare busy/rdata/error; on ready, pop and compare.
   always @(negedge clk) begin
      exp_t e;
      for (int u = 0; u < 2; u++) begin
         chk("busy", u, 32'(busy[u]), 32'((cyc >= bfrom[u]) && (cyc <= bto[u])));
         if (ready[u]) begin
            if (qsize(u) == 0) begin
               chk("spurious_ready", u, 32'(ready[u]), 32'd0);
            end else begin
               pop_exp(u, e);
               chk("ready_cycle", u, 32'(cyc), 32'(e.cyc));
               chk("rdata", u, rdata[u], e.rdata);
               chk("error", u, 32'(err[u]), 32'(e.err));
               shown[u] = e.rdata;
            end
         end else begin
            chk("error_idle", u, 32'(err[u]), 32'd0);
            chk("rdata_hold", u, rdata[u], shown[u]);
         end
      end
   end

   // Issue one request at the current cycle and wait until its ready pulse
   // has been consumed; returns in the first cycle after ready.
   task automatic req(input int u, input logic r, input logic w, input logic [31:0] a,
                      input logic [31:0] d, input bit drop);
      int   c;
      int   idx;
      bit   oor;
      bit   done;
      exp_t e;
      c = cyc;
      rd_en[u] = r;
      wr_en[u] = w;
      addr[u]  = a;
      wd[u]    = d;
      oor = (a[31:2] >= 30'(DEPTH));
      idx = int'(a[11:2]);
      if (w) begin
         if (!oor) mdl[u][idx] = d;
      end else begin
         last[u] = oor ? 32'h0 : mdl[u][idx];
      end
      e.cyc   = c + lat(u) + 1;
      e.rdata = last[u];
      e.err   = oor || (r && w);
      push_exp(u, e);
      bfrom[u] = c + 1;
      bto[u]   = c + lat(u) + 1;
      done = 0;
      for (int t = 1; t <= 40; t++) begin
         @(posedge clk);
         #1;
         if (qsize(u) == 0) begin
            done = 1;
            chk("ready_wait", u, 32'(t), 32'(lat(u) + 2));
            break;
         end
      end
      if (!done) begin
         chk("ready_timeout", u, 32'(qsize(u)), 32'd0);
         if (u == 0) q0.delete();
         else q1.delete();
      end
      if (drop) begin
         rd_en[u] = 1'b0;
         wr_en[u] = 1'b0;
      end
   endtask

   task automatic reset_pulse(input int n);
      rst_n = 1'b0;
      for (int u = 0; u < 2; u++) begin
         bto[u]   = -1;
         shown[u] = 32'h0;
         last[u]  = 32'h0;
         rd_en[u] = 1'b0;
         wr_en[u] = 1'b0;
      end
      q0.delete();
      q1.delete();
      repeat (n) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   initial begin
      int          c;
      logic [31:0] a;
      logic [29:0] word;
      int          op;
      for (int u = 0; u < 2; u++) begin
         rd_en[u] = 1'b0; wr_en[u] = 1'b0; addr[u] = 32'h0; wd[u] = 32'h0;
         last[u] = 32'h0; shown[u] = 32'h0; bfrom[u] = 1; bto[u] = 0;
      end
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (10) @(posedge clk);
      #1;

      req(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1);
      req(0, 1'b1, 1'b0, 32'h13, 32'h0, 1);

      req(1, 1'b0, 1'b1, 32'h0, 32'h1, 0);
      req(1, 1'b1, 1'b0, 32'h0, 32'h0, 1);
      req(1, 1'b1, 1'b0, 32'h0, 32'h0, 0);
      req(1, 1'b1, 1'b0, 32'h0, 32'h0, 1);

      req(0, 1'b0, 1'b1, 32'h0, 32'h12345678, 1);
      req(0, 1'b0, 1'b1, 32'h1000, 32'hFFFF, 1);
      req(0, 1'b1, 1'b0, 32'h1000, 32'h0, 1);
      req(0, 1'b1, 1'b0, 32'h0, 32'h0, 1);

      req(0, 1'b1, 1'b1, 32'h8, 32'hA5A5A5A5, 1);
      req(0, 1'b1, 1'b0, 32'h8, 32'h0, 1);

      // Abort a write with reset two cycles after acceptance.
      req(0, 1'b0, 1'b1, 32'h20, 32'h77, 1);
      c = cyc;
      wr_en[0] = 1'b1; addr[0] = 32'h20; wd[0] = 32'h55;
      bfrom[0] = c + 1; bto[0] = c + 5;
      @(posedge clk); #1;
      wr_en[0] = 1'b0;
      @(posedge clk); #1;
      reset_pulse(3);
      repeat (8) @(posedge clk);
      #1;
      req(0, 1'b1, 1'b0, 32'h20, 32'h0, 1);

      for (int u = 0; u < 2; u++) begin
         for (int w = 0; w < 16; w++) req(u, 1'b0, 1'b1, 32'(w * 4), $urandom, 1);
         for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 9) == 0) word = 30'(DEPTH + $urandom_range(0, 500));
            else word = 30'($urandom_range(0, 15));
            a  = {word, 2'($urandom_range(0, 3))};
            op = $urandom_range(0, 19);
            if (op < 10)      req(u, 1'b1, 1'b0, a, $urandom, $urandom_range(0, 3) != 0);
            else if (op < 17) req(u, 1'b0, 1'b1, a, $urandom, $urandom_range(0, 3) != 0);
            else              req(u, 1'b1, 1'b1, a, $urandom, $urandom_range(0, 3) != 0);
         end
         rd_en[u] = 1'b0;
         wr_en[u] = 1'b0;
         repeat (4) @(posedge clk);
         #1;
      end

      repeat (5) @(posedge clk);
      #1;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
